// File: rtl/stpu_boot_ctrl_if.sv
// Boot-path bus bundle: read channel to the boot source and write
// channel into the core's instruction memory.
interface stpu_boot_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Boot-source read channel
    logic              src_req;
    logic [ADDR_W-1:0] src_addr;
    logic              src_ack;
    logic [DATA_W-1:0] src_data;

    // Instruction-memory write channel
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    // Boot controller side
    modport master (
        output src_req,
        output src_addr,
        input  src_ack,
        input  src_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Boot source / instruction memory side
    modport slave (
        input  src_req,
        input  src_addr,
        output src_ack,
        output src_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/stpu_boot_ctrl.sv
// stpu_boot_ctrl: holds the stpu_sopc core in reset, copies IMG_WORDS
// words from a variable-latency boot source into instruction memory,
// optionally verifies a wrap-around checksum, then releases the core.
module stpu_boot_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int IMG_WORDS = 256,
    parameter int RST_HOLD  = 8,
    parameter int TIMEOUT   = 1023,
    parameter int CHECK_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    stpu_boot_ctrl_if.master bus,
    output logic             cpu_rst,
    output logic             boot_done,
    output logic             boot_err
);

    // Counter widths: each counter only ever needs to reach (limit - 1).
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int WAIT_W = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_REQ,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [HOLD_W-1:0] hold_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] sum_q;

    logic              sum_ok;
    logic              req_c;
    logic              we_c;
    logic              cpu_rst_c;
    logic              done_c;
    logic              err_c;

    // With checking disabled any image is accepted.
    assign sum_ok = (CHECK_EN == 0) || (sum_q == '0);

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HOLD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore outputs; outputs depend only on the state so
    // cpu_rst can only fall on the single transition into DONE.
    always_comb begin
        state_nx  = state;
        req_c     = 1'b0;
        we_c      = 1'b0;
        cpu_rst_c = 1'b1;
        done_c    = 1'b0;
        err_c     = 1'b0;
        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                req_c = 1'b1;
                // An ack in the final wait cycle still wins over the timeout.
                if (bus.src_ack) begin
                    state_nx = S_WRITE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_ERR;
                end
            end
            S_WRITE: begin
                we_c     = 1'b1;
                state_nx = (idx == IDX_LAST) ? S_CHECK : S_REQ;
            end
            S_CHECK: begin
                state_nx = sum_ok ? S_DONE : S_ERR;
            end
            S_DONE: begin
                cpu_rst_c = 1'b0;
                done_c    = 1'b1;
            end
            S_ERR: begin
                err_c = 1'b1;
            end
            default: begin
                state_nx = S_ERR;
            end
        endcase
    end

    // Datapath: hold timer, per-word wait timer, word index, captured
    // word and running checksum. Acks outside REQ never touch any of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            data_q   <= '0;
            sum_q    <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                S_REQ: begin
                    if (bus.src_ack) begin
                        data_q   <= bus.src_data;
                        sum_q    <= sum_q + bus.src_data;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                S_WRITE: begin
                    wait_cnt <= '0;
                    if (idx != IDX_LAST) begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address lines follow the word index; both are zero in reset.
    assign bus.src_req    = req_c;
    assign bus.src_addr   = idx;
    assign bus.imem_we    = we_c;
    assign bus.imem_addr  = idx;
    assign bus.imem_wdata = data_q;

    assign cpu_rst   = cpu_rst_c;
    assign boot_done = done_c;
    assign boot_err  = err_c;

endmodule

// File: tb/tb_stpu_boot_ctrl.sv
// Bench for stpu_boot_ctrl: two instances (TIMEOUT=20 with checksum,
// TIMEOUT=10 without), a reactive boot-source responder, and a
// cycle-by-cycle expected timeline built from the load rules.
module tb_stpu_boot_ctrl;
    localparam int H  = 5;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NT = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stpu_boot_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    stpu_boot_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    logic cr_a, bd_a, be_a, cr_b, bd_b, be_b;

    stpu_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(NW), .RST_HOLD(H),
                     .TIMEOUT(20), .CHECK_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master),
        .cpu_rst(cr_a), .boot_done(bd_a), .boot_err(be_a));

    stpu_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(NW), .RST_HOLD(H),
                     .TIMEOUT(10), .CHECK_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master),
        .cpu_rst(cr_b), .boot_done(bd_b), .boot_err(be_b));

    // Stimulus: only the selected instance sees acks.
    int          sel = 0;
    logic        ack_v = 1'b0;
    logic [31:0] data_v = '0;
    bit          spur = 0;
    assign bus_a.src_ack  = (sel == 0) && ack_v;
    assign bus_b.src_ack  = (sel != 0) && ack_v;
    assign bus_a.src_data = data_v;
    assign bus_b.src_data = data_v;

    logic          o_req, o_we, o_crst, o_done, o_err;
    logic [AW-1:0] o_addr, o_wa;
    logic [31:0]   o_wd;
    assign o_req  = (sel != 0) ? bus_b.src_req    : bus_a.src_req;
    assign o_addr = (sel != 0) ? bus_b.src_addr   : bus_a.src_addr;
    assign o_we   = (sel != 0) ? bus_b.imem_we    : bus_a.imem_we;
    assign o_wa   = (sel != 0) ? bus_b.imem_addr  : bus_a.imem_addr;
    assign o_wd   = (sel != 0) ? bus_b.imem_wdata : bus_a.imem_wdata;
    assign o_crst = (sel != 0) ? cr_b : cr_a;
    assign o_done = (sel != 0) ? bd_b : bd_a;
    assign o_err  = (sel != 0) ? be_b : be_a;

    // Scenario description
    logic [31:0] img [NW];
    int          lat [NW];

    // Expected timeline
    typedef struct {
        bit          req;
        int          addr;
        bit          we;
        logic [31:0] wd;
        bit          crst;
        bit          done;
        bit          err;
    } exp_t;
    exp_t ex [NT];
    int   m_end;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_t  = 0;
    int obs_done_t, obs_err_t, obs_writes;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (sel=%0d t=%0d): got %h want %h", nm, sel, cur_t, act, exp);
        end
    endfunction

    task automatic chk_reset(string nm);
        chk({nm, ".src_req"},    32'(o_req),  32'd0);
        chk({nm, ".src_addr"},   32'(o_addr), 32'd0);
        chk({nm, ".imem_we"},    32'(o_we),   32'd0);
        chk({nm, ".imem_addr"},  32'(o_wa),   32'd0);
        chk({nm, ".imem_wdata"}, o_wd,        32'd0);
        chk({nm, ".cpu_rst"},    32'(o_crst), 32'd1);
        chk({nm, ".boot_done"},  32'(o_done), 32'd0);
        chk({nm, ".boot_err"},   32'(o_err),  32'd0);
    endtask

    // Timeline from the rules: RST_HOLD idle cycles; per word (lat+1)
    // request cycles then one write; a word not acked within TIMEOUT
    // request cycles ends in error; one check cycle; then terminal.
    task automatic build(output int t_end);
        int          t;
        int          to;
        bit          cen;
        bit          failed;
        logic [31:0] s;
        to     = (sel != 0) ? 10 : 20;
        cen    = (sel == 0);
        failed = 0;
        s      = '0;
        for (int k = 0; k < NT; k++) ex[k] = '{0, 0, 0, 32'd0, 1, 0, 0};
        t = H;
        for (int i = 0; i < NW; i++) begin
            if (lat[i] >= to) begin
                for (int j = 0; j < to; j++) begin
                    ex[t].req = 1; ex[t].addr = i; t++;
                end
                failed = 1;
                break;
            end
            for (int j = 0; j <= lat[i]; j++) begin
                ex[t].req = 1; ex[t].addr = i; t++;
            end
            ex[t].we = 1; ex[t].addr = i; ex[t].wd = img[i]; t++;
            s = s + img[i];
        end
        if (!failed) begin
            t++;
            if (cen && s != 0) failed = 1;
        end
        t_end = t;
        for (int k = t; k < NT; k++) begin
            if (failed) ex[k].err = 1;
            else begin ex[k].crst = 0; ex[k].done = 1; end
        end
    endtask

    task automatic run(input int abort_at);
        int t_end;
        int wcnt;
        int a;
        wcnt = 0;
        build(t_end);
        m_end = t_end;
        rst = 1'b0; ack_v = 1'b0; data_v = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset("in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs_done_t = -1; obs_err_t = -1; obs_writes = 0;
        for (int t = 0; t <= t_end + 4; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            cur_t = t;
            chk("src_req", 32'(o_req), 32'(ex[t].req));
            if (ex[t].req) chk("src_addr", 32'(o_addr), ex[t].addr);
            chk("imem_we", 32'(o_we), 32'(ex[t].we));
            if (ex[t].we) begin
                chk("imem_addr", 32'(o_wa), ex[t].addr);
                chk("imem_wdata", o_wd, ex[t].wd);
            end
            chk("cpu_rst", 32'(o_crst), 32'(ex[t].crst));
            chk("boot_done", 32'(o_done), 32'(ex[t].done));
            chk("boot_err", 32'(o_err), 32'(ex[t].err));
            if (o_we) obs_writes++;
            if (o_done && obs_done_t < 0) obs_done_t = t;
            if (o_err && obs_err_t < 0) obs_err_t = t;
            if (t == abort_at) begin
                rst = 1'b0; ack_v = 1'b0;
                #1 chk_reset("abort");
                return;
            end
            // Responder: ack the request after lat[addr] extra cycles.
            if (o_req) begin
                a = int'(o_addr);
                if (a < NW && wcnt == lat[a]) begin
                    ack_v = 1'b1; data_v = img[a]; wcnt = 0;
                end else begin
                    ack_v = 1'b0; data_v = $urandom; wcnt++;
                end
            end else begin
                wcnt = 0;
                ack_v = spur;
                data_v = $urandom;
            end
        end
        ack_v = 1'b0;
    endtask

    initial begin
        // Normal load
        sel = 0; spur = 0;
        img = '{32'h1, 32'h2, 32'h3, 32'hFFFFFFFA};
        lat = '{0, 0, 0, 0};
        run(-1);
        cur_t = -1;
        chk("model_normal_end", m_end, H + 9);
        chk("normal_done_cycle", obs_done_t, H + 9);
        chk("normal_writes", obs_writes, 4);

        // Variable latency
        lat = '{0, 5, 1, 17};
        run(-1);
        cur_t = -1;
        chk("model_varlat_end", m_end, H + 9 + 23);
        chk("varlat_done_cycle", obs_done_t, H + 32);
        chk("varlat_writes", obs_writes, 4);

        // Timeout on word 2, TIMEOUT=10
        sel = 1;
        lat = '{0, 0, 255, 0};
        run(-1);
        cur_t = -1;
        chk("model_timeout_end", m_end, H + 14);
        chk("timeout_err_cycle", obs_err_t, H + 14);
        chk("timeout_writes", obs_writes, 2);
        chk("timeout_no_done", obs_done_t, -1);

        // Checksum failure, then same image with checking off
        sel = 0;
        img = '{32'h1, 32'h2, 32'h3, 32'hFFFFFFFB};
        lat = '{0, 0, 0, 0};
        run(-1);
        cur_t = -1;
        chk("cksum_err_cycle", obs_err_t, H + 9);
        chk("cksum_writes", obs_writes, 4);
        chk("cksum_no_done", obs_done_t, -1);
        sel = 1;
        run(-1);
        cur_t = -1;
        chk("nocheck_done_cycle", obs_done_t, H + 9);

        // Reset during REQ of word 2, then a clean restart
        sel = 0;
        img = '{32'h1, 32'h2, 32'h3, 32'hFFFFFFFA};
        run(H + 4);
        run(-1);
        cur_t = -1;
        chk("restart_done_cycle", obs_done_t, H + 9);

        // Spurious acks in every non-request cycle
        spur = 1;
        run(-1);
        cur_t = -1;
        chk("spur_done_cycle", obs_done_t, H + 9);
        chk("spur_writes", obs_writes, 4);

        // Randomized images, latencies (including timeout boundaries)
        for (int r = 0; r < 12; r++) begin
            int          to;
            logic [31:0] s;
            sel  = int'($urandom_range(0, 1));
            spur = bit'($urandom_range(0, 1));
            to   = (sel != 0) ? 10 : 20;
            s    = '0;
            for (int i = 0; i < NW; i++) begin
                img[i] = $urandom;
                case ($urandom_range(0, 11))
                    0:       lat[i] = to;
                    1:       lat[i] = to - 1;
                    default: lat[i] = int'($urandom_range(0, 4));
                endcase
                if (i < NW - 1) s = s + img[i];
            end
            if ($urandom_range(0, 3) != 0) img[NW-1] = -s;
            run(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
